// File: rtl/mem_arb_pkg.sv
// =============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and widths for the IFU/LSU memory arbiter.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_WOP_W  = 3;

    // Instruction fetches are always presented to memory as word reads.
    localparam logic [c_WOP_W-1:0] c_WOP_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_if.sv
// =============================================================================
// Module   : mem_arb_if
// Brief    : IFU, LSU and memory handshake bundle; slave = arbiter side.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int WOP_W  = c_WOP_W
) ();

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_rsp_valid;
    logic              ifu_rsp_ready;
    logic [DATA_W-1:0] ifu_rsp_data;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [WOP_W-1:0]  lsu_req_wop;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic              lsu_rsp_valid;
    logic              lsu_rsp_ready;
    logic [DATA_W-1:0] lsu_rsp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [WOP_W-1:0]  mem_req_wop;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [DATA_W-1:0] mem_rsp_data;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wop, lsu_req_wdata, lsu_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wop, mem_req_wdata, mem_rsp_ready
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wop, lsu_req_wdata, lsu_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wop, mem_req_wdata, mem_rsp_ready
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// =============================================================================
// Module   : mem_arb_grant
// Brief    : One-hot grant (bit0 IFU, bit1 LSU); LSU wins ties unless
//            MEM_ARB_RR_EN selects alternation on ties.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  wire logic       i_ifu_valid,
    input  wire logic       i_lsu_valid,
`ifdef MEM_ARB_RR_EN
    input  wire owner_t     i_last_owner,
`endif
    output logic [1:0]      o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_ifu_valid && i_lsu_valid) begin
`ifdef MEM_ARB_RR_EN
            o_grant = (i_last_owner == OWN_LSU) ? 2'b01 : 2'b10;
`else
            o_grant = 2'b10;
`endif
        end else if (i_lsu_valid) begin
            o_grant = 2'b10;
        end else if (i_ifu_valid) begin
            o_grant = 2'b01;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// =============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between IFU and LSU, one transaction in
//            flight. Define MEM_ARB_RR_EN for round-robin tie breaking.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    mem_arb_if.slave   bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    logic [c_ADDR_W-1:0] r_addr;
    logic                r_wen;
    logic [c_WOP_W-1:0]  r_wop;
    logic [c_DATA_W-1:0] r_wdata;

    logic [1:0]          w_grant;
    logic                w_idle;
    logic                w_in_rsp;
    logic                w_owner_rsp_ready;

    // Requests are refused while reset is held, even though state reads IDLE.
    assign w_idle            = (r_state == IDLE) && rst_n;
    assign w_in_rsp          = (r_state == RSP);
    assign w_owner_rsp_ready = (r_owner == OWN_LSU) ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;

    // The owner register only changes on a grant, so it doubles as last owner.
    mem_arb_grant u_grant (
        .i_ifu_valid  (bus.ifu_req_valid),
        .i_lsu_valid  (bus.lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .i_last_owner (r_owner),
`endif
        .o_grant      (w_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant != 2'b00) w_state_nxt = REQ;
            REQ:     if (bus.mem_req_ready) w_state_nxt = RSP;
            RSP:     if (bus.mem_rsp_valid && w_owner_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_IFU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wop   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle && w_grant[1]) begin
                r_owner <= OWN_LSU;
                r_addr  <= bus.lsu_req_addr;
                r_wen   <= bus.lsu_req_wen;
                r_wop   <= bus.lsu_req_wop;
                r_wdata <= bus.lsu_req_wdata;
            end else if (w_idle && w_grant[0]) begin
                r_owner <= OWN_IFU;
                r_addr  <= bus.ifu_req_addr;
                r_wen   <= 1'b0;
                r_wop   <= c_WOP_WORD;
                r_wdata <= '0;
            end
        end
    end

    assign bus.ifu_req_ready = w_idle && w_grant[0];
    assign bus.lsu_req_ready = w_idle && w_grant[1];

    assign bus.mem_req_valid = (r_state == REQ);
    assign bus.mem_req_addr  = r_addr;
    assign bus.mem_req_wen   = r_wen;
    assign bus.mem_req_wop   = r_wop;
    assign bus.mem_req_wdata = r_wdata;

    assign bus.ifu_rsp_valid = w_in_rsp && (r_owner == OWN_IFU) && bus.mem_rsp_valid;
    assign bus.lsu_rsp_valid = w_in_rsp && (r_owner == OWN_LSU) && bus.mem_rsp_valid;
    assign bus.ifu_rsp_data  = bus.mem_rsp_data;
    assign bus.lsu_rsp_data  = bus.mem_rsp_data;
    assign bus.mem_rsp_ready = w_in_rsp && w_owner_rsp_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// =============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and random checks of mem_arbiter against a transaction
//            model; build with MEM_ARB_RR_EN to cover round-robin ties.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arb_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Transaction model: busy = a request is owned, issued = memory accepted it.
    bit          m_busy, m_issued, m_own_lsu, m_last_lsu;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [2:0]  m_wop;
    bit          e_ifu_acc, e_lsu_acc;
    bit          ifu_pend, lsu_pend;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy     = 1'b0;
        m_issued   = 1'b0;
        m_own_lsu  = 1'b0;
        m_last_lsu = 1'b0;
    endfunction

    task automatic settle();
        bit iv, lv, own_rdy, e_mrv, e_irv, e_lrv, e_mrr;
        #1;
        iv = bus.ifu_req_valid;
        lv = bus.lsu_req_valid;
        e_ifu_acc = 1'b0;
        e_lsu_acc = 1'b0;
        if (rst_n && !m_busy) begin
            if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
                if (m_last_lsu) e_ifu_acc = 1'b1;
                else            e_lsu_acc = 1'b1;
`else
                e_lsu_acc = 1'b1;
`endif
            end else begin
                e_ifu_acc = iv;
                e_lsu_acc = lv;
            end
        end
        own_rdy = m_own_lsu ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;
        e_mrv   = rst_n && m_busy && !m_issued;
        e_irv   = rst_n && m_issued && !m_own_lsu && bus.mem_rsp_valid;
        e_lrv   = rst_n && m_issued &&  m_own_lsu && bus.mem_rsp_valid;
        e_mrr   = rst_n && m_issued && own_rdy;
        chk1("ifu_req_ready", bus.ifu_req_ready, e_ifu_acc);
        chk1("lsu_req_ready", bus.lsu_req_ready, e_lsu_acc);
        chk1("mem_req_valid", bus.mem_req_valid, e_mrv);
        chk1("ifu_rsp_valid", bus.ifu_rsp_valid, e_irv);
        chk1("lsu_rsp_valid", bus.lsu_rsp_valid, e_lrv);
        chk1("mem_rsp_ready", bus.mem_rsp_ready, e_mrr);
        if (e_mrv) begin
            chk32("mem_req_addr", bus.mem_req_addr, m_addr);
            chk1("mem_req_wen", bus.mem_req_wen, m_wen);
            chk32("mem_req_wop", {29'd0, bus.mem_req_wop}, {29'd0, m_wop});
            chk32("mem_req_wdata", bus.mem_req_wdata, m_wdata);
        end
        if (e_irv) chk32("ifu_rsp_data", bus.ifu_rsp_data, bus.mem_rsp_data);
        if (e_lrv && !m_wen) chk32("lsu_rsp_data", bus.lsu_rsp_data, bus.mem_rsp_data);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_issued) begin
            if (bus.mem_rsp_valid && (m_own_lsu ? bus.lsu_rsp_ready : bus.ifu_rsp_ready)) begin
                m_busy   = 1'b0;
                m_issued = 1'b0;
            end
        end else if (m_busy) begin
            if (bus.mem_req_ready) m_issued = 1'b1;
        end else if (e_ifu_acc || e_lsu_acc) begin
            m_busy     = 1'b1;
            m_own_lsu  = e_lsu_acc;
            m_last_lsu = e_lsu_acc;
            if (e_lsu_acc) begin
                m_addr  = bus.lsu_req_addr;
                m_wen   = bus.lsu_req_wen;
                m_wop   = bus.lsu_req_wop;
                m_wdata = bus.lsu_req_wdata;
                lsu_pend = 1'b0;
            end else begin
                m_addr  = bus.ifu_req_addr;
                m_wen   = 1'b0;
                m_wop   = c_WOP_WORD;
                m_wdata = 32'd0;
                ifu_pend = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drain();
        int n = 0;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = $urandom;
        bus.ifu_rsp_ready = 1'b1;
        bus.lsu_rsp_ready = 1'b1;
        while (m_busy && n < 20) begin
            step();
            n++;
        end
        if (m_busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic lsu_req(input logic [31:0] addr, input logic wen, input logic [2:0] wop,
                           input logic [31:0] wdata);
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = addr;
        bus.lsu_req_wen   = wen;
        bus.lsu_req_wop   = wop;
        bus.lsu_req_wdata = wdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0000;
        bus.ifu_rsp_ready = 1'b0;
        lsu_req(32'd0, 1'b0, 3'd0, 32'd0);
        bus.lsu_req_valid = 1'b0;
        bus.lsu_rsp_ready = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'd0;
        ifu_pend = 1'b0;
        lsu_pend = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset: nothing accepted, captured fields cleared.
        settle();
        chk1("rst_ifu_req_ready", bus.ifu_req_ready, 1'b0);
        chk32("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
        chk1("rst_mem_rsp_ready", bus.mem_rsp_ready, 1'b0);
        advance();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b0;

        // IFU fetch, zero-wait memory: accept T0, issue T1, response T2, next accept T3.
        bus.mem_req_ready = 1'b1;
        bus.ifu_rsp_ready = 1'b1;
        settle();
        chk1("t0_ifu_accept", bus.ifu_req_ready, 1'b1);
        advance();
        bus.ifu_req_valid = 1'b0;
        settle();
        chk1("t1_mem_req_valid", bus.mem_req_valid, 1'b1);
        chk32("t1_mem_req_addr", bus.mem_req_addr, 32'h8000_0000);
        advance();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0010_0073;
        settle();
        chk1("t2_ifu_rsp_valid", bus.ifu_rsp_valid, 1'b1);
        chk32("t2_ifu_rsp_data", bus.ifu_rsp_data, 32'h0010_0073);
        advance();
        bus.mem_rsp_valid = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0004;
        settle();
        chk1("t3_ifu_accept", bus.ifu_req_ready, 1'b1);
        advance();
        drain();

        // Tie: LSU load wins, IFU accepted once the LSU response is consumed.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0008;
        lsu_req(32'h8000_0100, 1'b0, 3'd2, 32'd0);
        bus.mem_req_ready = 1'b1;
        settle();
        chk1("tie_lsu_ready", bus.lsu_req_ready, 1'b1);
        chk1("tie_ifu_ready", bus.ifu_req_ready, 1'b0);
        advance();
        bus.lsu_req_valid = 1'b0;
        settle();
        chk32("tie_mem_addr", bus.mem_req_addr, 32'h8000_0100);
        advance();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1234_5678;
        settle();
        chk1("tie_lsu_rsp_valid", bus.lsu_rsp_valid, 1'b1);
        chk32("tie_lsu_rsp_data", bus.lsu_rsp_data, 32'h1234_5678);
        advance();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk1("tie_ifu_after", bus.ifu_req_ready, 1'b1);
        advance();
        drain();

        // Store held off by memory for three cycles.
        lsu_req(32'h8000_0200, 1'b1, 3'd2, 32'hDEAD_BEEF);
        bus.mem_req_ready = 1'b0;
        step();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_wdata = 32'd0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk1("st_valid", bus.mem_req_valid, 1'b1);
            chk1("st_wen", bus.mem_req_wen, 1'b1);
            chk32("st_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
            advance();
        end
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_rsp_valid = 1'b1;
        settle();
        chk1("st_ack", bus.lsu_rsp_valid, 1'b1);
        advance();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk1("st_idle", bus.mem_req_valid, 1'b0);
        advance();

        // Owner back-pressure in the response phase.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0010;
        bus.ifu_rsp_ready = 1'b0;
        step();
        bus.ifu_req_valid = 1'b0;
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0013;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0014;
        lsu_req(32'h8000_0300, 1'b0, 3'd4, 32'd0);
        for (int k = 0; k < 2; k++) begin
            settle();
            chk1("bp_mem_rsp_ready", bus.mem_rsp_ready, 1'b0);
            chk1("bp_ifu_req_ready", bus.ifu_req_ready, 1'b0);
            chk1("bp_lsu_req_ready", bus.lsu_req_ready, 1'b0);
            advance();
        end
        bus.ifu_rsp_ready = 1'b1;
        settle();
        chk1("bp_release", bus.mem_rsp_ready, 1'b1);
        advance();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk1("bp_next_lsu", bus.lsu_req_ready, 1'b1);
        advance();
        drain();

        // Asynchronous reset while a request sits on the memory port.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0020;
        bus.mem_req_ready = 1'b0;
        step();
        bus.ifu_req_valid = 1'b0;
        settle();
        chk1("ar_in_req", bus.mem_req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("ar_mem_req_valid", bus.mem_req_valid, 1'b0);
        chk32("ar_mem_req_addr", bus.mem_req_addr, 32'd0);
        model_reset();
        advance();
        rst_n = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h8000_0040;
        bus.mem_req_ready = 1'b1;
        settle();
        chk1("ar_accept", bus.ifu_req_ready, 1'b1);
        advance();
        bus.ifu_req_valid = 1'b0;
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hCAFE_F00D;
        settle();
        chk32("ar_rsp_data", bus.ifu_rsp_data, 32'hCAFE_F00D);
        advance();
        bus.mem_rsp_valid = 1'b0;

`ifdef MEM_ARB_RR_EN
        // LSU granted last, then continuous contention must alternate IFU, LSU, ...
        lsu_req(32'h8000_0400, 1'b0, 3'd2, 32'd0);
        step();
        drain();
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            bus.ifu_req_valid = 1'b1;
            bus.ifu_req_addr  = 32'h8000_0500 + 32'(k * 4);
            lsu_req(32'h8000_0600 + 32'(k * 4), 1'b0, 3'd2, 32'd0);
            bus.mem_req_ready = 1'b1;
            bus.mem_rsp_valid = 1'b1;
            settle();
            chk1("rr_ifu_grant", bus.ifu_req_ready, (k % 2) == 0);
            advance();
            while (m_busy && n < 10) begin
                step();
                n++;
            end
        end
        drain();
`endif

        // Random traffic against the model.
        ifu_pend = 1'b0;
        lsu_pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!ifu_pend && $urandom_range(3) == 0) begin
                ifu_pend = 1'b1;
                bus.ifu_req_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_pend && $urandom_range(3) == 0) begin
                lsu_pend = 1'b1;
                lsu_req($urandom, $urandom_range(1) == 1, 3'($urandom_range(7)), $urandom);
            end
            bus.ifu_req_valid = ifu_pend;
            bus.lsu_req_valid = lsu_pend;
            bus.mem_req_ready = ($urandom_range(2) != 0);
            bus.mem_rsp_valid = ($urandom_range(1) == 1);
            bus.mem_rsp_data  = $urandom;
            bus.ifu_rsp_ready = ($urandom_range(3) != 0);
            bus.lsu_rsp_ready = ($urandom_range(3) != 0);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
